// File: rtl/clock_pkg.sv
// Shared definitions for the multiplexed HH:MM[:SS] clock.
//   - seven-segment codes ({dp,g..a}, active-low) and the BCD -> segment decoder
//   - BCD time record and increment helpers
//   - digit positions relative to the minute-ones digit
//   - 24 h -> 12 h display mapping
package clock_pkg;

  localparam logic [7:0] SEG_0     = 8'hC0;
  localparam logic [7:0] SEG_1     = 8'hF9;
  localparam logic [7:0] SEG_2     = 8'hA4;
  localparam logic [7:0] SEG_3     = 8'hB0;
  localparam logic [7:0] SEG_4     = 8'h99;
  localparam logic [7:0] SEG_5     = 8'h92;
  localparam logic [7:0] SEG_6     = 8'h82;
  localparam logic [7:0] SEG_7     = 8'hF8;
  localparam logic [7:0] SEG_8     = 8'h80;
  localparam logic [7:0] SEG_9     = 8'h90;
  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [7:0] SEG_ERR   = 8'h7F;

  // Positions relative to the minute-ones digit; seconds sit below it when present.
  localparam int REL_SEC1  = -2;
  localparam int REL_SEC10 = -1;
  localparam int REL_MIN1  = 0;
  localparam int REL_MIN10 = 1;
  localparam int REL_HR1   = 2;
  localparam int REL_HR10  = 3;

  // BCD wrap points (tens in [7:4], ones in [3:0]).
  localparam logic [7:0] SEC_MAX = 8'h59;
  localparam logic [7:0] MIN_MAX = 8'h59;
  localparam logic [7:0] HR_MAX  = 8'h23;
  localparam logic [7:0] HR_NOON = 8'h12;

  typedef struct packed {
    logic [7:0] hh;
    logic [7:0] mm;
    logic [7:0] ss;
  } tm_t;

  function automatic bit digits_legal(input int n);
    return (n == 4) || (n == 6);
  endfunction

  function automatic logic [7:0] bcd_to_seg(input logic [3:0] d);
    case (d)
      4'd0:    return SEG_0;
      4'd1:    return SEG_1;
      4'd2:    return SEG_2;
      4'd3:    return SEG_3;
      4'd4:    return SEG_4;
      4'd5:    return SEG_5;
      4'd6:    return SEG_6;
      4'd7:    return SEG_7;
      4'd8:    return SEG_8;
      4'd9:    return SEG_9;
      default: return SEG_ERR;
    endcase
  endfunction

  // Two-digit BCD increment wrapping lim -> 00.
  function automatic logic [7:0] bcd_next(input logic [7:0] v, input logic [7:0] lim);
    if (v == lim) return 8'h00;
    if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
    return {v[7:4], v[3:0] + 4'd1};
  endfunction

  // 0 -> 12, 1..12 unchanged, 13..23 -> 1..11; result is BCD.
  function automatic logic [7:0] hr_to_12h(input logic [7:0] h24);
    logic [4:0] b;
    b = 5'(h24[7:4]) * 5'd10 + 5'(h24[3:0]);
    if (b == 5'd0) b = 5'd12;
    else if (b > 5'd12) b = b - 5'd12;
    return (b >= 5'd10) ? {4'd1, 4'(b - 5'd10)} : {4'd0, b[3:0]};
  endfunction

endpackage

// File: rtl/digital_clock_mux_if.sv
// Board-side bundle of the clock: run/set control, set buttons, display mode in;
// PM flag, segment bus and digit selects out.
//   en, min, hr, mode_12h : board -> clock
//   pm, out_data[7:0], out_select[NUM_DIGITS-1:0] : clock -> display
interface digital_clock_mux_if #(
  parameter int NUM_DIGITS = 6
);
  logic                  en;
  logic                  min;
  logic                  hr;
  logic                  mode_12h;
  logic                  pm;
  logic [7:0]            out_data;
  logic [NUM_DIGITS-1:0] out_select;

  modport master (output en, min, hr, mode_12h, input pm, out_data, out_select);
  modport slave  (input en, min, hr, mode_12h, output pm, out_data, out_select);
endinterface

// File: rtl/btn_debounce.sv
// Button debouncer: 2-flop synchroniser, then a counter of consecutive low samples.
// A single press pulse is issued on the DEBOUNCE_CYCLES-th consecutive low sample;
// the counter then saturates so a held button never repeats.
//   clk, rst (active-low, async) ; btn_n : raw active-low button ; press : one-cycle pulse
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 1_048_576
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_n,
  output logic press
);
  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    sync;
  logic [CW-1:0] cnt;
  logic          fired;
  logic          low;

  assign low = ~sync[1];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync  <= 2'b11;
      cnt   <= '0;
      fired <= 1'b0;
      press <= 1'b0;
    end else begin
      sync  <= {sync[0], btn_n};
      press <= 1'b0;
      if (!low) begin
        cnt   <= '0;
        fired <= 1'b0;
      end else if (cnt != CNT_MAX) begin
        cnt <= cnt + 1'b1;
      end else if (!fired) begin
        // fired keeps the saturated counter from re-issuing the pulse
        press <= 1'b1;
        fired <= 1'b1;
      end
    end
  end
endmodule

// File: rtl/digital_clock_mux.sv
// Fully synchronous HH:MM[:SS] clock with multiplexed seven-segment output.
//   clk  : system clock
//   rst  : asynchronous reset, active-low (deassertion synchronised internally)
//   bus  : slave side of digital_clock_mux_if
//          en=1 run / en=0 set; min, hr active-low set buttons; mode_12h display mode;
//          pm registered PM flag; out_data {dp,g..a} active-low; out_select one-cold, bit 0 rightmost.
// Time is stored as 24 h BCD. A 1 Hz tick enable from the divider advances it in run
// mode; debounced button pulses adjust it in set mode. A scan counter walks the digits.
module digital_clock_mux
  import clock_pkg::*;
#(
  parameter int CLK_HZ          = 50_000_000,
  parameter int DEBOUNCE_CYCLES = 1_048_576,
  parameter int SCAN_DIV        = 131_072,
  parameter int NUM_DIGITS      = 6
) (
  input logic                clk,
  input logic                rst,
  digital_clock_mux_if.slave bus
);
  localparam int DW   = $clog2(CLK_HZ);
  localparam int SW   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW   = 3;
  localparam int BASE = NUM_DIGITS - 4;
  localparam logic [DW-1:0] DIV_MAX  = DW'(CLK_HZ - 1);
  localparam logic [DW-1:0] DIV_HALF = DW'(CLK_HZ / 2);
  localparam logic [SW-1:0] SCAN_MAX = SW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IDX_MAX  = IW'(NUM_DIGITS - 1);

  if (!digits_legal(NUM_DIGITS)) begin : g_bad_num_digits
    $error("digital_clock_mux: NUM_DIGITS must be 4 or 6");
  end

  // Reset: asserts immediately, releases two clocks after rst rises.
  logic [1:0] rst_sync;
  logic       rst_n;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rst_sync <= 2'b00;
    else      rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_n = rst_sync[1];

  logic min_press, hr_press;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_min_db (
    .clk(clk), .rst(rst_n), .btn_n(bus.min), .press(min_press)
  );
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_hr_db (
    .clk(clk), .rst(rst_n), .btn_n(bus.hr), .press(hr_press)
  );

  // 1 Hz tick divider, free-running in both modes.
  logic [DW-1:0] div;
  logic          tick;

  assign tick = (div == DIV_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) div <= '0;
    else        div <= tick ? '0 : div + 1'b1;
  end

  // Time counters. All carries resolve combinationally so the full rollover
  // lands on the tick edge.
  tm_t tm, tm_nx;

  always_comb begin
    tm_nx = tm;
    if (bus.en) begin
      if (tick) begin
        tm_nx.ss = bcd_next(tm.ss, SEC_MAX);
        if (tm.ss == SEC_MAX) begin
          tm_nx.mm = bcd_next(tm.mm, MIN_MAX);
          if (tm.mm == MIN_MAX) tm_nx.hh = bcd_next(tm.hh, HR_MAX);
        end
      end
    end else begin
      if (min_press) tm_nx.mm = bcd_next(tm.mm, MIN_MAX);
      if (hr_press)  tm_nx.hh = bcd_next(tm.hh, HR_MAX);
      if (min_press || hr_press) tm_nx.ss = 8'h00;
    end
  end

  // pm is taken from the next-state hour so it flips on the same edge as the hour.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tm     <= '0;
      bus.pm <= 1'b0;
    end else begin
      tm     <= tm_nx;
      bus.pm <= (tm_nx.hh >= HR_NOON);
    end
  end

  // Digit scan.
  logic [SW-1:0] scan_cnt;
  logic          strobe, strobe_q;
  logic [IW-1:0] idx;

  assign strobe = (scan_cnt == SCAN_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_cnt <= '0;
      strobe_q <= 1'b0;
      idx      <= '0;
    end else begin
      scan_cnt <= strobe ? '0 : scan_cnt + 1'b1;
      strobe_q <= strobe;
      if (strobe_q) idx <= (idx == IDX_MAX) ? '0 : idx + 1'b1;
    end
  end

  // Display mux: selected digit -> segments.
  logic [7:0]            hh_disp;
  logic [7:0]            seg;
  logic [NUM_DIGITS-1:0] sel;
  int                    rel;

  assign hh_disp = bus.mode_12h ? hr_to_12h(tm.hh) : tm.hh;

  always_comb begin
    rel = int'(idx) - BASE;
    seg = SEG_BLANK;
    case (rel)
      REL_SEC1:  seg = bcd_to_seg(tm.ss[3:0]);
      REL_SEC10: seg = bcd_to_seg(tm.ss[7:4]);
      REL_MIN1:  seg = bcd_to_seg(tm.mm[3:0]);
      REL_MIN10: seg = bcd_to_seg(tm.mm[7:4]);
      REL_HR1: begin
        seg = bcd_to_seg(hh_disp[3:0]);
        // dp on the hour-ones digit acts as the blinking colon
        if (div < DIV_HALF) seg[7] = 1'b0;
      end
      REL_HR10:  seg = (bus.mode_12h && hh_disp[7:4] == 4'd0) ? SEG_BLANK
                                                              : bcd_to_seg(hh_disp[7:4]);
      default:   seg = SEG_BLANK;
    endcase
    for (int i = 0; i < NUM_DIGITS; i++) sel[i] = (idx != IW'(i));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.out_data   <= SEG_BLANK;
      bus.out_select <= '1;
    end else if (strobe_q) begin
      bus.out_data   <= seg;
      bus.out_select <= sel;
    end
  end

endmodule

// File: tb/tb_digital_clock_mux.sv
// Directed bench for digital_clock_mux with CLK_HZ=10, DEBOUNCE_CYCLES=4, SCAN_DIV=2, 6 digits.
// Expected times go into a scoreboard queue as stimulus is issued and are popped when checked.
module tb_digital_clock_mux;
  import clock_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  digital_clock_mux_if #(.NUM_DIGITS(6)) bus ();

  digital_clock_mux #(
    .CLK_HZ(10), .DEBOUNCE_CYCLES(4), .SCAN_DIV(2), .NUM_DIGITS(6)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  int n_assert = 0;
  int n_fail   = 0;
  int ecnt;

  // posedges since rst release; used to predict the divider phase seen by the colon
  always @(posedge clk) begin
    if (!rst) ecnt <= 0;
    else      ecnt <= ecnt + 1;
  end

  typedef struct {
    string      tag;
    logic [23:0] val;
  } exp_t;
  exp_t sb[$];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic expect_time(input string tag, input logic [7:0] h, input logic [7:0] m,
                             input logic [7:0] s);
    exp_t e;
    e.tag = tag;
    e.val = {h, m, s};
    sb.push_back(e);
  endtask

  task automatic check_time();
    exp_t e;
    n_assert++;
    assert (sb.size() != 0) else begin
      n_fail++;
      $error("FAIL sb_empty: observed %0d entries expected >0", sb.size());
    end
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk(e.tag, 32'(dut.tm), 32'(e.val));
    end
  endtask

  task automatic push_btn(input bit m, input bit h, input int cyc);
    @(negedge clk);
    bus.min = m ? 1'b0 : 1'b1;
    bus.hr  = h ? 1'b0 : 1'b1;
    repeat (cyc) @(negedge clk);
    bus.min = 1'b1;
    bus.hr  = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic press_n(input bit m, input bit h, input int n);
    for (int k = 0; k < n; k++) push_btn(m, h, 6);
  endtask

  task automatic wait_ss(input logic [7:0] t, input int budget, input string tag);
    int i;
    i = 0;
    while (i < budget && dut.tm.ss !== t) begin
      @(negedge clk);
      i++;
    end
    chk(tag, 32'(i < budget), 32'd1);
  endtask

  task automatic get_digit(input int pos, output logic [7:0] data);
    logic [5:0] one, want;
    int i;
    one  = 6'b1;
    want = ~(one << pos);
    repeat (13) @(negedge clk);
    i = 0;
    while (i < 20 && bus.out_select !== want) begin
      @(negedge clk);
      i++;
    end
    chk($sformatf("sel_wait_pos%0d", pos), 32'(i < 20), 32'd1);
    data = bus.out_data;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    logic [5:0] one, last, exp_sel;
    logic [7:0] exp_dat, d;
    tm_t        prev;
    int         i;

    one = 6'b1;
    bus.en = 1'b0; bus.min = 1'b1; bus.hr = 1'b1; bus.mode_12h = 1'b0;

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_sel", 32'(bus.out_select), 32'h3F);
    chk("rst_data", 32'(bus.out_data), 32'hFF);
    chk("rst_pm", 32'(bus.pm), 32'h0);
    expect_time("rst_time", 8'h00, 8'h00, 8'h00);
    check_time();

    // scan walk at 00:00:00 with colon phase
    rst  = 1'b1;
    last = bus.out_select;
    for (int k = 0; k < 30; k++) begin
      i = 0;
      while (i < 8 && bus.out_select === last) begin
        @(negedge clk);
        i++;
      end
      chk("scan_wait", 32'(i < 8), 32'd1);
      exp_sel = ~(one << (k % 6));
      chk($sformatf("scan_sel%0d", k), 32'(bus.out_select), 32'(exp_sel));
      exp_dat = 8'hC0;
      if ((k % 6) == 4 && ((ecnt - 3) % 10) < 5) exp_dat = 8'h40;
      chk($sformatf("scan_data%0d", k), 32'(bus.out_data), 32'(exp_dat));
      last = bus.out_select;
    end

    // set 12:34, run to :56, then reset mid-count
    press_n(0, 1, 12);
    press_n(1, 0, 34);
    expect_time("set_1234", 8'h12, 8'h34, 8'h00);
    check_time();
    chk("pm_1234", 32'(bus.pm), 32'h1);
    bus.en = 1'b1;
    wait_ss(8'h56, 700, "wait_56");
    bus.en = 1'b0;
    expect_time("run_123456", 8'h12, 8'h34, 8'h56);
    check_time();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_sel", 32'(bus.out_select), 32'h3F);
    chk("midrst_data", 32'(bus.out_data), 32'hFF);
    chk("midrst_pm", 32'(bus.pm), 32'h0);
    expect_time("midrst_time", 8'h00, 8'h00, 8'h00);
    check_time();
    rst = 1'b1;
    repeat (3) @(negedge clk);

    // 23:59 preload, minute wrap without hour carry, then run across midnight
    press_n(0, 1, 23);
    press_n(1, 0, 59);
    expect_time("set_2359", 8'h23, 8'h59, 8'h00);
    check_time();
    push_btn(1, 0, 6);
    expect_time("min_wrap", 8'h23, 8'h00, 8'h00);
    check_time();
    press_n(1, 0, 59);
    expect_time("reset_2359", 8'h23, 8'h59, 8'h00);
    check_time();
    bus.en = 1'b1;
    wait_ss(8'h58, 700, "wait_58");
    expect_time("run_235958", 8'h23, 8'h59, 8'h58);
    check_time();
    wait_ss(8'h59, 15, "wait_59");
    expect_time("run_235959", 8'h23, 8'h59, 8'h59);
    check_time();
    chk("pm_before_midnight", 32'(bus.pm), 32'h1);
    prev = dut.tm;
    i = 0;
    while (i < 15 && dut.tm === prev) begin
      @(negedge clk);
      i++;
    end
    bus.en = 1'b0;
    chk("wait_midnight", 32'(i < 15), 32'd1);
    expect_time("midnight", 8'h00, 8'h00, 8'h00);
    check_time();
    chk("pm_midnight", 32'(bus.pm), 32'h0);

    // debounce: short glitch ignored, long hold = one step, run mode ignores buttons
    push_btn(1, 0, 3);
    expect_time("bounce_3", 8'h00, 8'h00, 8'h00);
    check_time();
    push_btn(1, 0, 10);
    expect_time("hold_10", 8'h00, 8'h01, 8'h00);
    check_time();
    bus.en = 1'b1;
    push_btn(1, 1, 6);
    bus.en = 1'b0;
    chk("run_ignores_btn", 32'({dut.tm.hh, dut.tm.mm}), 32'h0001);

    // simultaneous presses at 09:59:30
    do_reset();
    press_n(0, 1, 9);
    press_n(1, 0, 59);
    expect_time("set_0959", 8'h09, 8'h59, 8'h00);
    check_time();
    bus.en = 1'b1;
    wait_ss(8'h30, 400, "wait_30");
    bus.en = 1'b0;
    expect_time("run_095930", 8'h09, 8'h59, 8'h30);
    check_time();
    push_btn(1, 1, 6);
    expect_time("both_press", 8'h10, 8'h00, 8'h00);
    check_time();

    // 12 h display
    do_reset();
    bus.mode_12h = 1'b1;
    get_digit(5, d);
    chk("h12_00_tens", 32'(d), 32'hF9);
    get_digit(4, d);
    chk("h12_00_ones", 32'(d | 8'h80), 32'hA4);
    get_digit(3, d);
    chk("h12_00_min10", 32'(d), 32'hC0);
    chk("h12_00_pm", 32'(bus.pm), 32'h0);
    press_n(0, 1, 13);
    expect_time("set_13", 8'h13, 8'h00, 8'h00);
    check_time();
    chk("h12_13_pm", 32'(bus.pm), 32'h1);
    get_digit(5, d);
    chk("h12_13_tens", 32'(d), 32'hFF);
    get_digit(4, d);
    chk("h12_13_ones", 32'(d | 8'h80), 32'hF9);
    bus.mode_12h = 1'b0;
    get_digit(5, d);
    chk("h24_13_tens", 32'(d), 32'hF9);
    get_digit(4, d);
    chk("h24_13_ones", 32'(d | 8'h80), 32'hB0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
